// File: rtl/mem_line_responder.sv
// Memory-side responder for the cache-to-memory line bus (A2/D2/C2).
// Serves whole-line READ_LINE / WRITE_LINE commands from a line-addressed
// array after a fixed access latency, answering on the shared tri-state
// D2/C2 wires. Array contents survive RESET; only control state is cleared.
module mem_line_responder #(
  parameter int ADDR_WIDTH  = 15,
  parameter int LINE_SIZE   = 16,
  parameter int MEM_LATENCY = 100
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] A2,
  inout  wire  [15:0]           D2,
  inout  wire  [1:0]            C2
);

  localparam int WORDS     = LINE_SIZE / 2;
  localparam int LINE_BITS = LINE_SIZE * 8;
  localparam int CW        = $clog2(MEM_LATENCY + 1);
  localparam int BW        = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_RESP  = 2'd1,
    CMD_READ  = 2'd2,
    CMD_WRITE = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_RX,
    S_WAIT,
    S_RD_TX,
    S_WR_ACK
  } state_e;

  // Byte i of a line lives at bits [8*i +: 8]. Beat k carries byte
  // LINE_SIZE-2-2k in its upper half and the following byte in its lower half.
  function automatic logic [LINE_BITS-1:0] put_beat(
    input logic [LINE_BITS-1:0] line,
    input int unsigned          k,
    input logic [15:0]          data
  );
    logic [LINE_BITS-1:0] res;
    int unsigned          i;
    res = line;
    i   = LINE_SIZE - 2 - 2 * k;
    res[8*i     +: 8] = data[15:8];
    res[8*(i+1) +: 8] = data[7:0];
    return res;
  endfunction

  function automatic logic [15:0] get_beat(
    input logic [LINE_BITS-1:0] line,
    input int unsigned          k
  );
    int unsigned i;
    i = LINE_SIZE - 2 - 2 * k;
    return {line[8*i +: 8], line[8*(i+1) +: 8]};
  endfunction

  logic [LINE_BITS-1:0]  mem_q [0:(1<<ADDR_WIDTH)-1];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic                  op_wr_q, op_wr_d;
  logic [CW-1:0]         cnt_q,   cnt_d;
  logic [BW-1:0]         beat_q,  beat_d;
  logic [LINE_BITS-1:0]  line_q,  line_d;
  logic                  mem_we;
  logic                  start_wait;
  logic                  start_resp;
  logic                  drv_c2;
  logic                  drv_d2;
  logic [15:0]           d2_out;

  // Next-state logic: command decode, beat collection, latency count and
  // response sequencing. The latency and response entry paths are shared
  // through start_wait/start_resp so a latency of 1 can skip WAIT entirely.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    op_wr_d    = op_wr_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    line_d     = line_q;
    mem_we     = 1'b0;
    start_wait = 1'b0;
    start_resp = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (C2 == CMD_READ) begin
          addr_d     = A2;
          op_wr_d    = 1'b0;
          start_wait = 1'b1;
        end else if (C2 == CMD_WRITE) begin
          addr_d  = A2;
          op_wr_d = 1'b1;
          line_d  = put_beat(line_q, 32'd0, D2);
          if (WORDS == 1) begin
            start_wait = 1'b1;
          end else begin
            state_d = S_WR_RX;
            beat_d  = BW'(1);
          end
        end
      end

      S_WR_RX: begin
        line_d = put_beat(line_q, 32'(beat_q), D2);
        if (beat_q == BW'(WORDS - 1)) begin
          start_wait = 1'b1;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(2)) begin
          start_resp = 1'b1;
        end
      end

      S_RD_TX: begin
        if (beat_q == BW'(WORDS - 1)) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end

      S_WR_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Counter holds MEM_LATENCY on the first WAIT cycle; the response is
    // entered when it would reach 1, giving exactly MEM_LATENCY cycles.
    if (start_wait) begin
      if (MEM_LATENCY == 1) begin
        start_resp = 1'b1;
      end else begin
        state_d = S_WAIT;
        cnt_d   = CW'(MEM_LATENCY);
      end
    end

    if (start_resp) begin
      if (op_wr_d) begin
        state_d = S_WR_ACK;
        mem_we  = 1'b1;
      end else begin
        state_d = S_RD_TX;
        beat_d  = '0;
        line_d  = mem_q[addr_d];
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      op_wr_q <= 1'b0;
      cnt_q   <= '0;
      beat_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_wr_q <= op_wr_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
    end
  end

  // Line commit on entry to WR_ACK; a coincident reset discards the write.
  always_ff @(posedge clk) begin
    if (mem_we && !RESET) begin
      mem_q[addr_d] <= line_d;
    end
  end

  // Bus drive enables and outgoing read beat, all from registered state.
  always_comb begin
    drv_c2 = (state_q == S_RD_TX) || (state_q == S_WR_ACK);
    drv_d2 = (state_q == S_RD_TX);
    d2_out = get_beat(line_q, 32'(beat_q));
  end

  assign (supply1, strong0) C2 = drv_c2 ? CMD_RESP : 2'bzz;
  assign D2 = drv_d2 ? d2_out : 16'bz;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed plus randomized bench for mem_line_responder with a line-level
// reference model (address -> list of beats, absent lines read as zero).
// Released bus reads as C2=0 (pulldown) and D2=16'hFFFF (pullup).
module tb_mem_line_responder;

  localparam int AW  = 15;
  localparam int LS  = 16;
  localparam int W   = LS / 2;
  localparam int LAT = 4;

  logic          clk;
  logic          RESET;
  logic [AW-1:0] A2;
  logic [15:0]   d_drv;
  logic          d_en;
  logic [1:0]    c_drv;
  logic          c_en;
  tri1  [15:0]   D2;
  tri0  [1:0]    C2;

  assign D2 = d_en ? d_drv : 16'bz;
  assign C2 = c_en ? c_drv : 2'bzz;

  mem_line_responder #(
    .ADDR_WIDTH (AW),
    .LINE_SIZE  (LS),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .RESET(RESET),
    .A2   (A2),
    .D2   (D2),
    .C2   (C2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference memory: beat k of a line at bits [16*k +: 16].
  logic [16*W-1:0] model [int unsigned];

  function automatic logic [16*W-1:0] model_line(input logic [AW-1:0] a);
    if (model.exists(int'(a))) return model[int'(a)];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_released(input string tag);
    #1;
    chk({tag, "_c2"}, 32'(C2), 32'd0);
    chk({tag, "_d2"}, 32'(D2), 32'h0000FFFF);
  endtask

  // Read transaction with exact latency check. rst_beat >= 0 asserts RESET
  // during that response beat; inj issues a second READ during the wait.
  task automatic do_read(input logic [AW-1:0] addr, input int rst_beat,
                         input bit inj, input logic [AW-1:0] inj_addr);
    logic [16*W-1:0] exp;
    bit              cut;
    exp = model_line(addr);
    cut = 1'b0;
    c_en = 1'b1; c_drv = 2'd2; A2 = addr;
    step();
    c_en = 1'b0; A2 = '0;
    for (int n = 1; n < LAT; n++) begin
      if (inj && n == 2) begin
        c_en = 1'b1; c_drv = 2'd2; A2 = inj_addr;
      end else begin
        c_en = 1'b0;
        chk_released("rd_wait");
      end
      step();
    end
    c_en = 1'b0; A2 = '0;
    for (int k = 0; k < W && !cut; k++) begin
      #1;
      chk("rd_resp_c2", 32'(C2), 32'd1);
      chk("rd_beat", 32'(D2), 32'(exp[16*k +: 16]));
      if (k == rst_beat) begin
        RESET = 1'b1;
        cut   = 1'b1;
      end
      step();
      RESET = 1'b0;
    end
    chk_released(cut ? "rd_trunc" : "rd_end");
    step();
  endtask

  // Write transaction; rst_beat >= 1 asserts RESET on that data beat.
  task automatic do_write(input logic [AW-1:0] addr, input logic [16*W-1:0] line,
                          input int rst_beat);
    bit cut;
    cut = 1'b0;
    c_en = 1'b1; c_drv = 2'd3; A2 = addr; d_en = 1'b1; d_drv = line[15:0];
    step();
    c_en = 1'b0; A2 = '0;
    for (int k = 1; k < W && !cut; k++) begin
      d_drv = line[16*k +: 16];
      if (k == rst_beat) begin
        RESET = 1'b1;
        cut   = 1'b1;
      end
      step();
      RESET = 1'b0;
    end
    d_en = 1'b0;
    if (cut) begin
      for (int n = 0; n < LAT + 2; n++) begin
        chk_released("wr_abort");
        step();
      end
    end else begin
      for (int n = 1; n < LAT; n++) begin
        chk_released("wr_wait");
        step();
      end
      #1;
      chk("wr_ack_c2", 32'(C2), 32'd1);
      chk("wr_ack_d2", 32'(D2), 32'h0000FFFF);
      step();
      chk_released("wr_end");
      step();
      model[int'(addr)] = line;
    end
  endtask

  initial begin
    logic [16*W-1:0] pat;
    logic [AW-1:0]   pool [4];
    logic [AW-1:0]   ra;

    RESET = 1'b1; A2 = '0; d_en = 1'b0; d_drv = '0; c_en = 1'b0; c_drv = '0;

    // Reset held two cycles, then ten idle cycles with bus released.
    step();
    step();
    chk_released("reset");
    RESET = 1'b0;
    for (int n = 0; n < 10; n++) begin
      c_en = 1'b1; c_drv = 2'd0;
      step();
      c_en = 1'b0;
      chk_released("idle");
    end
    step();

    // Fresh memory reads as zero.
    do_read(15'h0005, -1, 1'b0, '0);

    // Write then read back the same beats.
    pat = {16'h1100, 16'h3C2D, 16'h5A4B, 16'h7869,
           16'h9687, 16'hB4A5, 16'hD2C3, 16'hF0E1};
    do_write(15'h1234, pat, -1);
    do_read(15'h1234, -1, 1'b0, '0);

    // Command during WAIT is ignored: only the first line is returned.
    do_write(15'h0001, {$urandom, $urandom, $urandom, $urandom}, -1);
    do_read(15'h1234, -1, 1'b1, 15'h0001);
    for (int n = 0; n < 2 * (LAT + W); n++) begin
      chk_released("no_second_resp");
      step();
    end

    // Reset on the 5th write beat: no partial commit.
    do_write(15'h0002, {W{16'hAAAA}}, 4);
    do_read(15'h0002, -1, 1'b0, '0);

    // Reset on the 3rd read beat truncates; next read is served normally.
    do_read(15'h1234, 2, 1'b0, '0);
    do_read(15'h1234, -1, 1'b0, '0);

    // Randomized traffic over a small address pool including the top line.
    pool[0] = 15'h0005; pool[1] = 15'h1234; pool[2] = 15'h7FFF; pool[3] = 15'h0000;
    for (int t = 0; t < 24; t++) begin
      ra = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 1) begin
        do_write(ra, {$urandom, $urandom, $urandom, $urandom}, -1);
      end else begin
        do_read(ra, -1, 1'b0, '0);
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        chk_released("gap");
        step();
      end
    end
    for (int a = 0; a < 4; a++) begin
      do_read(pool[a], -1, 1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
